// File: rtl/serial_word_receiver.sv
// Serial-in/parallel-out word receiver with a single-entry holding register
// and valid/ready handshake; the next word is collected while one is held.
module serial_word_receiver #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       Serial_In,
  input  logic                       Bit_Valid,
  input  logic                       Clear,
  input  logic                       Word_Ready,
  output logic [WIDTH-1:0]           Parallel_Out,
  output logic                       Word_Valid,
  output logic                       Overrun,
  output logic [$clog2(WIDTH)-1:0]   Bit_Count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             take_bit;
  logic             complete;

  // Clear outranks Bit_Valid, so a cleared bit can never complete a word.
  always_comb begin
    take_bit = Bit_Valid && !Clear;
    complete = take_bit && (Bit_Count == LAST_BIT);
    if (MSB_FIRST) shift_next = {shift_reg[WIDTH-2:0], Serial_In};
    else           shift_next = {Serial_In, shift_reg[WIDTH-1:1]};
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state        <= EMPTY;
      shift_reg    <= '0;
      Bit_Count    <= '0;
      Parallel_Out <= '0;
      Overrun      <= 1'b0;
    end else begin
      if (Clear) begin
        shift_reg <= '0;
        Bit_Count <= '0;
        Overrun   <= 1'b0;
      end else if (Bit_Valid) begin
        shift_reg <= shift_next;
        Bit_Count <= complete ? '0 : Bit_Count + 1'b1;
      end

      // The completed word is taken from shift_next so it is visible right after its last bit.
      case (state)
        EMPTY: begin
          if (complete) begin
            Parallel_Out <= shift_next;
            state        <= FULL;
          end
        end
        default: begin
          if (complete) begin
            if (Word_Ready) Parallel_Out <= shift_next;
            else            Overrun      <= 1'b1;
          end else if (Word_Ready) begin
            state <= EMPTY;
          end
        end
      endcase
    end
  end

  assign Word_Valid = (state == FULL);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: an MSB-first and an LSB-first
// instance share stimulus and are checked every cycle against a queue model.
module tb_serial_word_receiver;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1, sin = 1'b0, bv = 1'b0, clr = 1'b0, rdy = 1'b0;

  logic [W-1:0] po_m, po_l;
  logic         wv_m, wv_l, ov_m, ov_l;
  logic [1:0]   bc_m, bc_l;

  int n_chk  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  bit           q[$];
  logic [W-1:0] m_word [2];
  logic         m_valid[2];
  logic         m_ovr  [2];

  always #5 clk = ~clk;

  serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .CLK(clk), .Reset(rst), .Serial_In(sin), .Bit_Valid(bv), .Clear(clr),
    .Word_Ready(rdy), .Parallel_Out(po_m), .Word_Valid(wv_m),
    .Overrun(ov_m), .Bit_Count(bc_m));

  serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(clk), .Reset(rst), .Serial_In(sin), .Bit_Valid(bv), .Clear(clr),
    .Word_Ready(rdy), .Parallel_Out(po_l), .Word_Valid(wv_l),
    .Overrun(ov_l), .Bit_Count(bc_l));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: bits gathered in a queue; a full queue becomes a word in the
  // order each instance assembles it, then the holding rules apply.
  task automatic model_step();
    bit           comp;
    logic [W-1:0] w_msb, w_lsb, nw;
    comp  = 1'b0;
    w_msb = '0;
    w_lsb = '0;
    if (rst) begin
      q.delete();
      for (int k = 0; k < 2; k++) begin
        m_word[k] = '0; m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
      end
    end else begin
      if (clr) begin
        q.delete();
        m_ovr[0] = 1'b0;
        m_ovr[1] = 1'b0;
      end else if (bv) begin
        q.push_back(sin);
        if (q.size() == W) begin
          comp = 1'b1;
          for (int i = 0; i < W; i++) begin
            w_msb[W-1-i] = q[i];
            w_lsb[i]     = q[i];
          end
          q.delete();
        end
      end
      for (int k = 0; k < 2; k++) begin
        nw = (k == 0) ? w_msb : w_lsb;
        if (!m_valid[k]) begin
          if (comp) begin m_word[k] = nw; m_valid[k] = 1'b1; end
        end else if (comp) begin
          if (rdy) m_word[k] = nw;
          else     m_ovr[k]  = 1'b1;
        end else if (rdy) begin
          m_valid[k] = 1'b0;
        end
      end
    end
    run = 1'b1;
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("po_msb", 32'(po_m), 32'(m_word[0]));
      chk("wv_msb", 32'(wv_m), 32'(m_valid[0]));
      chk("ov_msb", 32'(ov_m), 32'(m_ovr[0]));
      chk("bc_msb", 32'(bc_m), 32'(q.size()));
      chk("po_lsb", 32'(po_l), 32'(m_word[1]));
      chk("wv_lsb", 32'(wv_l), 32'(m_valid[1]));
      chk("ov_lsb", 32'(ov_l), 32'(m_ovr[1]));
      chk("bc_lsb", 32'(bc_l), 32'(q.size()));
    end
  end

  task automatic cyc(input logic r, input logic s, input logic v, input logic c, input logic k);
    rst = r; sin = s; bv = v; clr = c; rdy = k;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic send(input logic s, input logic k = 1'b0);
    cyc(1'b0, s, 1'b1, 1'b0, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic accept();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_word(input logic [3:0] w, input logic last_rdy);
    logic [3:0] t;
    t = w;
    for (int i = 3; i >= 0; i--) send(t[i], (i == 0) ? last_rdy : 1'b0);
  endtask

  initial begin
    logic [3:0] sr;

    // Reset held two cycles with Bit_Valid high
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_po", 32'(po_m), 32'h0);
    chk("rst_wv", 32'(wv_m), 32'h0);
    chk("rst_ov", 32'(ov_m), 32'h0);
    chk("rst_bc", 32'(bc_m), 32'h0);

    // Consecutive bits 1,0,1,1
    send(1'b1); chk("bc_step1", 32'(bc_m), 32'd1);
    send(1'b0); chk("bc_step2", 32'(bc_m), 32'd2);
    send(1'b1); chk("bc_step3", 32'(bc_m), 32'd3);
    chk("wv_before_last", 32'(wv_m), 32'h0);
    send(1'b1); chk("bc_wrap", 32'(bc_m), 32'd0);
    chk("word_1011", 32'(po_m), 32'hB);
    chk("wv_after_last", 32'(wv_m), 32'h1);
    chk("lsb_word_1101", 32'(po_l), 32'hD);
    accept();
    chk("wv_consumed", 32'(wv_m), 32'h0);

    // Same bits with idle gaps
    send(1'b1); idle(1);
    send(1'b0); idle(2);
    send(1'b1); idle(3);
    chk("gap_bc3", 32'(bc_m), 32'd3);
    send(1'b1);
    chk("gap_word", 32'(po_m), 32'hB);
    chk("gap_bc0", 32'(bc_m), 32'd0);
    accept();

    // Back-to-back words, ready on the second completion edge
    send_word(4'b1011, 1'b0);
    send_word(4'b0110, 1'b1);
    chk("b2b_word", 32'(po_m), 32'h6);
    chk("b2b_wv", 32'(wv_m), 32'h1);
    chk("b2b_ov", 32'(ov_m), 32'h0);
    accept();

    // Overrun, then Clear
    send_word(4'b1011, 1'b0);
    send_word(4'b0110, 1'b0);
    chk("ovr_word_kept", 32'(po_m), 32'hB);
    chk("ovr_set", 32'(ov_m), 32'h1);
    idle(2);
    chk("ovr_sticky", 32'(ov_m), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_ovr", 32'(ov_m), 32'h0);
    chk("clr_wv_kept", 32'(wv_m), 32'h1);
    accept();
    // Word_Ready while empty is ignored
    accept();
    chk("ready_empty", 32'(wv_m), 32'h0);

    // Clear coinciding with Bit_Valid mid-word
    send(1'b1); send(1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_bc", 32'(bc_m), 32'd0);
    send_word(4'b0100, 1'b0);
    chk("after_clr_word", 32'(po_m), 32'h4);
    accept();

    // Reset mid-word
    send(1'b1); send(1'b0); send(1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("midrst_po", 32'(po_m), 32'h0);
    chk("midrst_wv", 32'(wv_m), 32'h0);
    chk("midrst_bc", 32'(bc_m), 32'h0);
    send(1'b1);
    chk("midrst_nowd", 32'(wv_m), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Clear on a would-be completion edge produces no word
    send(1'b1); send(1'b1); send(1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_complete_wv", 32'(wv_m), 32'h0);

    // Reset while holding a word mid-handshake
    send_word(4'b1111, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_hold_wv", 32'(wv_m), 32'h0);
    chk("rst_hold_po", 32'(po_m), 32'h0);

    // LSB-first instance: bits 1,1,0,0
    send(1'b1); send(1'b1); send(1'b0); send(1'b0);
    chk("lsb_word_0011", 32'(po_l), 32'h3);
    chk("msb_word_1100", 32'(po_m), 32'hC);
    accept();

    // Loopback of a 4-bit shift register holding 1001, shifted out bit 0 first
    sr = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      send(sr[0]);
      sr = {1'b0, sr[3:1]};
    end
    chk("loop_lsb", 32'(po_l), 32'h9);
    chk("loop_msb", 32'(po_m), 32'h9);
    idle(2);

    #2;
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
